// File: rtl/tri_pkg.sv
// Shared types for the triangle feeder: vertex/triangle layout and the issue FSM states.
package tri_pkg;

    typedef struct packed {
        logic [2:0] y;
        logic [2:0] x;
    } vertex_t;

    // Vertex 1 sits in the low bits so the packed layout matches the 18-bit host word.
    typedef struct packed {
        vertex_t v3;
        vertex_t v2;
        vertex_t v1;
    } triangle_t;

    typedef enum logic [2:0] {
        IDLE,
        V1,
        V2,
        V3,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_t;

    localparam logic [6:0] PIX_MAX = 7'd127;

endpackage

// File: rtl/tri_fifo.sv
// Synchronous show-ahead FIFO of whole triangles; full/empty come from an occupancy count.
module tri_fifo
    import tri_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  triangle_t din,
    output triangle_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    triangle_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/tri_feeder.sv
// Buffers host triangles and serialises them onto the engine's nt/xi/yi port, pacing on busy.
// Optional po counting is enabled with the TRI_FEEDER_PIXCNT_EN macro.
module tri_feeder
    import tri_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [17:0] in_tri,
    output logic        in_ready,
    output logic        nt,
    output logic [2:0]  xi,
    output logic [2:0]  yi,
    input  logic        busy,
    input  logic        po,
    output logic        tri_done,
    output logic [6:0]  pix_cnt,
    output logic        idle
);

    state_t    state;
    state_t    next_state;
    triangle_t tri_q;
    triangle_t fifo_head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      pop;

    tri_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop),
        .din   (triangle_t'(in_tri)),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign idle     = (state == IDLE) && fifo_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            tri_q <= '0;
        end else begin
            state <= next_state;
            if (pop) tri_q <= fifo_head;
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty && !busy) begin
                    pop        = 1'b1;
                    next_state = V1;
                end
            end
            V1:      next_state = V2;
            V2:      next_state = V3;
            V3:      next_state = WAIT_HI;
            WAIT_HI: if (busy)  next_state = WAIT_LO;
            WAIT_LO: if (!busy) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Engine-facing outputs depend only on the registered state and latched triangle.
    always_comb begin
        nt       = 1'b0;
        xi       = '0;
        yi       = '0;
        tri_done = 1'b0;
        unique case (state)
            V1: begin
                nt = 1'b1;
                xi = tri_q.v1.x;
                yi = tri_q.v1.y;
            end
            V2: begin
                xi = tri_q.v2.x;
                yi = tri_q.v2.y;
            end
            V3: begin
                xi = tri_q.v3.x;
                yi = tri_q.v3.y;
            end
            DONE:    tri_done = 1'b1;
            default: ;
        endcase
    end

`ifdef TRI_FEEDER_PIXCNT_EN
    logic [6:0] pix_q;

    // Cleared as a triangle is popped, so it holds the finished count through DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_q <= '0;
        end else if (pop) begin
            pix_q <= '0;
        end else if ((state == WAIT_HI || state == WAIT_LO) && po && pix_q != PIX_MAX) begin
            pix_q <= pix_q + 1'b1;
        end
    end

    assign pix_cnt = pix_q;
`else
    logic unused_po;

    assign unused_po = po;
    assign pix_cnt   = '0;
`endif

endmodule

// File: tb/tb_tri_feeder.sv
// Directed self-checking bench for tri_feeder; pix_cnt expectations follow TRI_FEEDER_PIXCNT_EN.
module tb_tri_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [17:0] in_tri;
    logic        in_ready;
    logic        nt;
    logic [2:0]  xi;
    logic [2:0]  yi;
    logic        busy;
    logic        po;
    logic        tri_done;
    logic [6:0]  pix_cnt;
    logic        idle;

    int checks = 0;
    int errors = 0;

    tri_feeder #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_tri   (in_tri),
        .in_ready (in_ready),
        .nt       (nt),
        .xi       (xi),
        .yi       (yi),
        .busy     (busy),
        .po       (po),
        .tri_done (tri_done),
        .pix_cnt  (pix_cnt),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] mk(input int x1, y1, x2, y2, x3, y3);
        return {3'(y3), 3'(x3), 3'(y2), 3'(x2), 3'(y1), 3'(x1)};
    endfunction

    function automatic logic [6:0] exp_pix(input int n);
`ifdef TRI_FEEDER_PIXCNT_EN
        return (n > 127) ? 7'd127 : 7'(n);
`else
        return 7'd0 + 7'(n - n);
`endif
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Engine model: entered in WAIT_HI, returns in the cycle where DONE should be visible.
    task automatic engine_run(input int npo);
        busy = 1'b1;
        po   = 1'b0;
        next_cycle();
        repeat (npo) begin
            po = 1'b1;
            next_cycle();
        end
        po   = 1'b0;
        busy = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; in_tri = '0; busy = 1'b0; po = 1'b0;
        next_cycle();
        next_cycle();
        checks += 7;
        if (nt !== 1'b0)       begin errors++; $display("[TB] FAIL reset_nt got %0b expected 0", nt); end
        if (xi !== 3'd0)       begin errors++; $display("[TB] FAIL reset_xi got %0d expected 0", xi); end
        if (yi !== 3'd0)       begin errors++; $display("[TB] FAIL reset_yi got %0d expected 0", yi); end
        if (tri_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_tri_done got %0b expected 0", tri_done); end
        if (pix_cnt !== 7'd0)  begin errors++; $display("[TB] FAIL reset_pix_cnt got %0d expected 0", pix_cnt); end
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b expected 1", in_ready); end
        if (idle !== 1'b1)     begin errors++; $display("[TB] FAIL reset_idle got %0b expected 1", idle); end
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_basic;
        int ex[3] = '{1, 5, 1};
        int ey[3] = '{2, 2, 6};
        in_tri = mk(1, 2, 5, 2, 1, 6);
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_in_ready got %0b expected 1", in_ready); end
        next_cycle();
        in_valid = 1'b0;
        checks += 2;
        if (nt !== 1'b0)   begin errors++; $display("[TB] FAIL basic_latency_nt got %0b expected 0", nt); end
        if (idle !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_busy got %0b expected 0", idle); end
        next_cycle();
        for (int v = 0; v < 3; v++) begin
            checks += 3;
            if (nt !== (v == 0)) begin errors++; $display("[TB] FAIL basic_nt_v%0d got %0b expected %0b", v, nt, v == 0); end
            if (xi !== 3'(ex[v])) begin errors++; $display("[TB] FAIL basic_xi_v%0d got %0d expected %0d", v, xi, ex[v]); end
            if (yi !== 3'(ey[v])) begin errors++; $display("[TB] FAIL basic_yi_v%0d got %0d expected %0d", v, yi, ey[v]); end
            next_cycle();
        end
        checks++;
        if (xi !== 3'd0) begin errors++; $display("[TB] FAIL basic_xi_wait got %0d expected 0", xi); end
        engine_run(15);
        checks += 2;
        if (tri_done !== 1'b1)        begin errors++; $display("[TB] FAIL basic_tri_done got %0b expected 1", tri_done); end
        if (pix_cnt !== exp_pix(15))  begin errors++; $display("[TB] FAIL basic_pix_cnt got %0d expected %0d", pix_cnt, exp_pix(15)); end
        next_cycle();
        checks += 2;
        if (tri_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse got %0b expected 0", tri_done); end
        if (idle !== 1'b1)     begin errors++; $display("[TB] FAIL basic_idle_after got %0b expected 1", idle); end
    endtask

    task automatic test_fifo_full;
        logic [17:0] t [5];
        int w;
        for (int i = 0; i < 5; i++)
            t[i] = mk(i, 2*i + 1, i + 1, 2*i + 2, i + 2, 2*i + 3);
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_tri = t[i];
            in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_push%0d got %0b expected 1", i, in_ready); end
            next_cycle();
        end
        in_tri = t[4];
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_after4 got %0b expected 0", in_ready); end
        next_cycle();
        checks += 2;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_hold got %0b expected 0", in_ready); end
        if (nt !== 1'b0)       begin errors++; $display("[TB] FAIL full_no_issue got %0b expected 0", nt); end
        busy = 1'b0;
        next_cycle();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_after_pop got %0b expected 1", in_ready); end
        for (int i = 0; i < 5; i++) begin
            w = 0;
            while (nt !== 1'b1 && w < 10) begin
                next_cycle();
                w++;
            end
            checks++;
            if (nt !== 1'b1) begin errors++; $display("[TB] FAIL full_issue%0d_timeout got %0b expected 1", i, nt); end
            for (int v = 0; v < 3; v++) begin
                checks += 2;
                if (xi !== 3'(i + v))       begin errors++; $display("[TB] FAIL full_t%0d_xi_v%0d got %0d expected %0d", i, v, xi, 3'(i + v)); end
                if (yi !== 3'(2*i + v + 1)) begin errors++; $display("[TB] FAIL full_t%0d_yi_v%0d got %0d expected %0d", i, v, yi, 3'(2*i + v + 1)); end
                next_cycle();
                in_valid = 1'b0;
            end
            engine_run(i + 2);
            checks += 2;
            if (tri_done !== 1'b1)          begin errors++; $display("[TB] FAIL full_t%0d_done got %0b expected 1", i, tri_done); end
            if (pix_cnt !== exp_pix(i + 2)) begin errors++; $display("[TB] FAIL full_t%0d_pix got %0d expected %0d", i, pix_cnt, exp_pix(i + 2)); end
            next_cycle();
            checks++;
            if (nt !== 1'b0) begin errors++; $display("[TB] FAIL full_t%0d_gap_nt got %0b expected 0", i, nt); end
        end
        checks++;
        if (idle !== 1'b1) begin errors++; $display("[TB] FAIL full_idle_end got %0b expected 1", idle); end
    endtask

    task automatic test_busy_block;
        int ex[3] = '{7, 0, 3};
        int ey[3] = '{0, 7, 4};
        busy = 1'b1;
        in_tri = mk(7, 0, 0, 7, 3, 4);
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        repeat (4) begin
            checks += 2;
            if (nt !== 1'b0)   begin errors++; $display("[TB] FAIL block_nt got %0b expected 0", nt); end
            if (idle !== 1'b0) begin errors++; $display("[TB] FAIL block_idle got %0b expected 0", idle); end
            next_cycle();
        end
        busy = 1'b0;
        next_cycle();
        for (int v = 0; v < 3; v++) begin
            checks += 3;
            if (nt !== (v == 0))  begin errors++; $display("[TB] FAIL block_nt_v%0d got %0b expected %0b", v, nt, v == 0); end
            if (xi !== 3'(ex[v])) begin errors++; $display("[TB] FAIL block_xi_v%0d got %0d expected %0d", v, xi, ex[v]); end
            if (yi !== 3'(ey[v])) begin errors++; $display("[TB] FAIL block_yi_v%0d got %0d expected %0d", v, yi, ey[v]); end
            next_cycle();
        end
        engine_run(3);
        checks += 2;
        if (tri_done !== 1'b1)      begin errors++; $display("[TB] FAIL block_done got %0b expected 1", tri_done); end
        if (pix_cnt !== exp_pix(3)) begin errors++; $display("[TB] FAIL block_pix got %0d expected %0d", pix_cnt, exp_pix(3)); end
        next_cycle();
    endtask

    task automatic test_saturate;
        int w = 0;
        in_tri = mk(2, 3, 4, 5, 6, 7);
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        while (nt !== 1'b1 && w < 10) begin
            next_cycle();
            w++;
        end
        checks++;
        if (nt !== 1'b1) begin errors++; $display("[TB] FAIL sat_issue_timeout got %0b expected 1", nt); end
        repeat (3) next_cycle();
        engine_run(130);
        checks += 2;
        if (tri_done !== 1'b1)        begin errors++; $display("[TB] FAIL sat_done got %0b expected 1", tri_done); end
        if (pix_cnt !== exp_pix(130)) begin errors++; $display("[TB] FAIL sat_pix got %0d expected %0d", pix_cnt, exp_pix(130)); end
        next_cycle();
    endtask

    task automatic test_reset_mid;
        int w = 0;
        in_tri = mk(3, 3, 4, 4, 5, 5);
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        while (nt !== 1'b1 && w < 10) begin
            next_cycle();
            w++;
        end
        repeat (3) next_cycle();
        busy = 1'b1;
        next_cycle();
        po = 1'b1;
        in_tri = mk(6, 6, 6, 6, 6, 6);
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        checks++;
        if (idle !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pre_idle got %0b expected 0", idle); end
        #2;
        rst = 1'b0;
        #1;
        checks += 7;
        if (nt !== 1'b0)       begin errors++; $display("[TB] FAIL midrst_nt got %0b expected 0", nt); end
        if (xi !== 3'd0)       begin errors++; $display("[TB] FAIL midrst_xi got %0d expected 0", xi); end
        if (yi !== 3'd0)       begin errors++; $display("[TB] FAIL midrst_yi got %0d expected 0", yi); end
        if (tri_done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_tri_done got %0b expected 0", tri_done); end
        if (pix_cnt !== 7'd0)  begin errors++; $display("[TB] FAIL midrst_pix got %0d expected 0", pix_cnt); end
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready got %0b expected 1", in_ready); end
        if (idle !== 1'b1)     begin errors++; $display("[TB] FAIL midrst_idle got %0b expected 1", idle); end
        busy = 1'b0;
        po = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        repeat (6) begin
            next_cycle();
            checks += 3;
            if (tri_done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_done got %0b expected 0", tri_done); end
            if (nt !== 1'b0)       begin errors++; $display("[TB] FAIL midrst_fifo_empty_nt got %0b expected 0", nt); end
            if (idle !== 1'b1)     begin errors++; $display("[TB] FAIL midrst_idle_after got %0b expected 1", idle); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fifo_full();
        test_busy_block();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
